// File: rtl/vga_text_term_pkg.sv
// -----------------------------------------------------------------------------
// vga_text_term_pkg
// Shared definitions for the character terminal front end:
//   - console control codes (backspace, line feed, form feed, carriage return)
//   - ROW_WORDS: number of 32-bit RAM words per text row (128 bytes / 4)
//   - FSM state encoding
//   - cell_word(): maps a (row, col) cursor to its RAM word address
// -----------------------------------------------------------------------------
package vga_text_term_pkg;

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  localparam int ROW_WORDS = 32;

  typedef enum logic [1:0] {
    ST_CLEAR_ALL  = 2'd0,
    ST_IDLE       = 2'd1,
    ST_SCROLL_CP  = 2'd2,
    ST_SCROLL_CLR = 2'd3
  } state_e;

  // Byte address is row*128 + col, so the word address is simply the row
  // concatenated with the upper five column bits.
  function automatic logic [9:0] cell_word(input logic [4:0] row, input logic [6:0] col);
    return {row, col[6:2]};
  endfunction

endpackage

// File: rtl/vga_text_term_text_ram.sv
// -----------------------------------------------------------------------------
// vga_text_term_text_ram
// 1024 x 32 text RAM, four characters per word.
// Ports:
//   clk_i        clock
//   clrn_i       synchronous active-low reset (clears only the VGA read register)
//   a_we_i       engine write enable
//   a_be_i       engine byte-lane enables (lane 0 = bits [7:0])
//   a_waddr_i    engine write word address
//   a_wdata_i    engine write data
//   a_raddr_i    engine read word address (used by the scroll copy)
//   a_rdata_o    engine read data, registered (one cycle latency)
//   b_addr_i     VGA read word address
//   b_rdata_o    VGA read data, registered (one cycle latency)
// A read of a word being written in the same cycle returns the old contents.
// -----------------------------------------------------------------------------
module vga_text_term_text_ram (
  input  logic        clk_i,
  input  logic        clrn_i,
  input  logic        a_we_i,
  input  logic [3:0]  a_be_i,
  input  logic [9:0]  a_waddr_i,
  input  logic [31:0] a_wdata_i,
  input  logic [9:0]  a_raddr_i,
  output logic [31:0] a_rdata_o,
  input  logic [9:0]  b_addr_i,
  output logic [31:0] b_rdata_o
);

  logic [31:0] mem_q [0:1023];

  always_ff @(posedge clk_i) begin
    if (a_we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (a_be_i[i]) begin
          mem_q[a_waddr_i][i*8 +: 8] <= a_wdata_i[i*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    a_rdata_o <= mem_q[a_raddr_i];
  end

  always_ff @(posedge clk_i) begin
    if (!clrn_i) begin
      b_rdata_o <= '0;
    end else begin
      b_rdata_o <= mem_q[b_addr_i];
    end
  end

endmodule

// File: rtl/vga_text_term.sv
// -----------------------------------------------------------------------------
// vga_text_term
// Character terminal front end: accepts ASCII bytes from the CPU console port,
// interprets control codes, tracks the cursor and writes the text RAM that the
// VGA renderer reads. Running past the last row scrolls the screen up a row.
// Ports:
//   CLOCK_50      system clock
//   clrn          synchronous active-low reset
//   wr_en         character valid
//   wr_char       ASCII byte
//   ready         character can be accepted this cycle
//   inquire_addr  VGA word address
//   data          text word at inquire_addr from the previous cycle
//   cursor_row    cursor row
//   cursor_col    cursor column
// -----------------------------------------------------------------------------
module vga_text_term
  import vga_text_term_pkg::*;
#(
  parameter int         ROWS  = 30,
  parameter int         COLS  = 70,
  parameter logic [7:0] BLANK = 8'h20
) (
  input  logic        CLOCK_50,
  input  logic        clrn,
  input  logic        wr_en,
  input  logic [7:0]  wr_char,
  output logic        ready,
  input  logic [9:0]  inquire_addr,
  output logic [31:0] data,
  output logic [4:0]  cursor_row,
  output logic [6:0]  cursor_col
);

  localparam logic [9:0] CLR_LAST = 10'(ROWS * ROW_WORDS - 1);
  localparam logic [9:0] CP_LAST  = 10'((ROWS - 1) * ROW_WORDS);
  localparam logic [9:0] ROW_LAST = 10'(ROW_WORDS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
  localparam logic [6:0] LAST_COL = 7'(COLS - 1);

  state_e      state_q;
  logic [9:0]  cnt_q;
  logic [4:0]  row_q;
  logic [6:0]  col_q;
  logic        ready_q;

  logic        accept;
  logic        is_print;
  logic [6:0]  col_dec;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [9:0]  ram_waddr;
  logic [31:0] ram_wdata;
  logic [9:0]  ram_raddr;
  logic [31:0] ram_rdata;

  assign accept   = wr_en && ready_q;
  assign is_print = (wr_char >= 8'h20) && (wr_char <= 8'h7E);
  assign col_dec  = col_q - 7'd1;

  // RAM write port decode. Every write lands on the edge that ends the cycle,
  // so a character is stored on its accept edge.
  always_comb begin
    ram_we    = 1'b0;
    ram_be    = 4'h0;
    ram_waddr = '0;
    ram_wdata = {4{BLANK}};
    // Copy pipeline: read i+32 now, store it to word i on the next cycle.
    ram_raddr = cnt_q + 10'(ROW_WORDS);
    case (state_q)
      ST_CLEAR_ALL: begin
        ram_we    = 1'b1;
        ram_be    = 4'hF;
        ram_waddr = cnt_q;
      end
      ST_SCROLL_CP: begin
        // First cycle only primes the read; nothing to store yet.
        if (cnt_q != 10'd0) begin
          ram_we    = 1'b1;
          ram_be    = 4'hF;
          ram_waddr = cnt_q - 10'd1;
          ram_wdata = ram_rdata;
        end
      end
      ST_SCROLL_CLR: begin
        ram_we    = 1'b1;
        ram_be    = 4'hF;
        ram_waddr = CP_LAST + cnt_q;
      end
      ST_IDLE: begin
        if (accept) begin
          if (is_print) begin
            ram_we    = 1'b1;
            ram_be    = 4'b0001 << col_q[1:0];
            ram_waddr = cell_word(row_q, col_q);
            ram_wdata = {4{wr_char}};
          end else if (wr_char == CH_BS && col_q != 7'd0) begin
            ram_we    = 1'b1;
            ram_be    = 4'b0001 << col_dec[1:0];
            ram_waddr = cell_word(row_q, col_dec);
          end
        end
      end
      default: ;
    endcase
    if (!clrn) begin
      ram_we = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!clrn) begin
      state_q <= ST_CLEAR_ALL;
      cnt_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR_ALL: begin
          if (cnt_q == CLR_LAST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 10'd1;
          end
        end
        ST_SCROLL_CP: begin
          // Runs one cycle beyond the last read to drain the pipeline.
          if (cnt_q == CP_LAST) begin
            state_q <= ST_SCROLL_CLR;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 10'd1;
          end
        end
        ST_SCROLL_CLR: begin
          if (cnt_q == ROW_LAST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 10'd1;
          end
        end
        ST_IDLE: begin
          if (accept) begin
            if ((is_print && col_q == LAST_COL) || wr_char == CH_LF) begin
              col_q <= '0;
              if (row_q == LAST_ROW) begin
                state_q <= ST_SCROLL_CP;
                cnt_q   <= '0;
                ready_q <= 1'b0;
              end else begin
                row_q <= row_q + 5'd1;
              end
            end else if (is_print) begin
              col_q <= col_q + 7'd1;
            end else if (wr_char == CH_CR) begin
              col_q <= '0;
            end else if (wr_char == CH_BS) begin
              if (col_q != 7'd0) begin
                col_q <= col_dec;
              end
            end else if (wr_char == CH_FF) begin
              state_q <= ST_CLEAR_ALL;
              cnt_q   <= '0;
              row_q   <= '0;
              col_q   <= '0;
              ready_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= ST_CLEAR_ALL;
          cnt_q   <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  vga_text_term_text_ram u_text_ram (
    .clk_i     (CLOCK_50),
    .clrn_i    (clrn),
    .a_we_i    (ram_we),
    .a_be_i    (ram_be),
    .a_waddr_i (ram_waddr),
    .a_wdata_i (ram_wdata),
    .a_raddr_i (ram_raddr),
    .a_rdata_o (ram_rdata),
    .b_addr_i  (inquire_addr),
    .b_rdata_o (data)
  );

  assign ready      = ready_q;
  assign cursor_row = row_q;
  assign cursor_col = col_q;

endmodule
